// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer: Set-2 prefix bytes,
// sequencer states and the key-event record carried through the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FE = 8'hFE;
  localparam logic [7:0] PS2_00 = 8'h00;
  localparam logic [7:0] PS2_FF = 8'hFF;

  // Pause is E1 followed by seven more bytes that carry no extra information.
  localparam logic [2:0] PS2_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } evt_t;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_00) || (b == PS2_FF);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead key-event FIFO with count-based full/empty; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  evt_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage is left unreset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 Set-2 scan-code sequencer: folds E0/F0/E1 prefixes into key events,
// tracks the held key, times out stalled sequences. PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic [7:0] held_code,
  output logic       err,
  output logic       overflow
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e        state_q;
  logic [2:0]    skip_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    held_q;
  logic          held_ext_q;
  logic          err_q;
  logic          ovf_q;

  logic          err_byte;
  logic          evt_fire;
  evt_t          evt_d;
  logic          repeat_drop;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  evt_t          head;

  assign err_byte = byte_valid && is_err_byte(byte_in) && (state_q != ST_SKIP);

  always_comb begin
    evt_fire = 1'b0;
    evt_d    = '0;
    evt_d.code = byte_in;
    if (byte_valid && !err_byte) begin
      case (state_q)
        ST_IDLE: evt_fire = !(byte_in inside {PS2_E0, PS2_F0, PS2_E1, PS2_AA, PS2_FA, PS2_FE});
        ST_EXT: begin
          evt_fire  = (byte_in != PS2_F0);
          evt_d.ext = 1'b1;
        end
        ST_BRK: begin
          evt_fire  = 1'b1;
          evt_d.brk = 1'b1;
        end
        ST_EXT_BRK: begin
          evt_fire  = 1'b1;
          evt_d.brk = 1'b1;
          evt_d.ext = 1'b1;
        end
        ST_SKIP: begin
          evt_fire   = (skip_q == 3'd1);
          evt_d.code = PS2_E1;
        end
        default: evt_fire = 1'b0;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeat_drop = !evt_d.brk && (evt_d.code == held_q) && (evt_d.ext == held_ext_q);
`else
  assign repeat_drop = 1'b0;
`endif

  assign push = evt_fire && !repeat_drop;
  assign pop  = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      tmo_q      <= '0;
      held_q     <= '0;
      held_ext_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (byte_valid) begin
        tmo_q <= '0;
        if (err_byte) begin
          state_q <= ST_IDLE;
          err_q   <= 1'b1;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (byte_in == PS2_E0) state_q <= ST_EXT;
              else if (byte_in == PS2_F0) state_q <= ST_BRK;
              else if (byte_in == PS2_E1) begin
                state_q <= ST_SKIP;
                skip_q  <= PS2_SKIP_LEN;
              end
            end
            ST_EXT:  state_q <= (byte_in == PS2_F0) ? ST_EXT_BRK : ST_IDLE;
            ST_SKIP: begin
              if (skip_q == 3'd1) state_q <= ST_IDLE;
              skip_q <= skip_q - 3'd1;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end else if (state_q != ST_IDLE) begin
        // A stalled prefix sequence is abandoned rather than glued to later bytes.
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q <= ST_IDLE;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end

      if (evt_fire) begin
        if (!evt_d.brk) begin
          held_q     <= evt_d.code;
          held_ext_q <= evt_d.ext;
        end else if ((evt_d.code == held_q) && (evt_d.ext == held_ext_q)) begin
          held_q     <= '0;
          held_ext_q <= 1'b0;
        end
      end

      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (evt_d),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_break = head.brk;
  assign evt_ext   = head.ext;
  assign held_code = held_q;
  assign err       = err_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Scan-code sequencer between the PS/2 byte receiver and its consumers (7-segment display driver, future host logic). It takes received bytes, resolves the Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events, and buffers the events in a small FIFO behind a valid/ready handshake. It also tracks the currently held key for display and aborts stalled prefix sequences with a timeout.

## Interface
- `TIMEOUT_CYC`, 50000: idle cycles allowed between bytes of one multi-byte sequence (1 ms at 50 MHz).
- `DEPTH`, 4: event FIFO depth; power of two, minimum 2.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `byte_in`  in  8  received scan byte; sampled only when `byte_valid`=1.
- `byte_valid`  in  1  one-cycle strobe, already synchronised to `clk`.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head when `evt_valid`&&`evt_ready`.
- `evt_code`  out  8  key code of the head event; 0x00 when empty.
- `evt_break`  out  1  head event is a release.
- `evt_ext`  out  1  head event was E0-prefixed.
- `held_code`  out  8  last pressed non-extended or extended key still down; 0x00 when none.
- `err`  out  1  one-cycle pulse on timeout or on a keyboard error byte.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (after E1).
- IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter = 7; 0xAA/0xFA/0xFE are discarded; 0x00/0xFF -> `err` pulse; any other byte -> make event {code, break=0, ext=0}.
- EXT: F0 -> EXT_BRK; other byte -> make event with ext=1 -> IDLE.
- BRK: byte -> break event with ext=0 -> IDLE. EXT_BRK: byte -> break event with ext=1 -> IDLE.
- SKIP: each byte decrements the counter. The 7th byte emits make event {0xE1, 0, 0} -> IDLE.
- 0x00/0xFF arriving in any state except SKIP: `err` pulse, no event, -> IDLE.
- Timeout: a counter clears on every `byte_valid` and runs in every state except IDLE. When it reaches `TIMEOUT_CYC`-1: -> IDLE, `err` pulse, partial sequence discarded.
- `held_code`: set to code on a make; cleared to 0x00 on a break whose code and ext match the held key. Breaks of other keys leave it unchanged.
- FIFO: push when an event is produced. Full and no pop: event dropped, `overflow` set. Full with a pop in the same cycle: push accepted. Empty: outputs 0, `evt_valid`=0.
- Reset mid-sequence: state IDLE, FIFO flushed, counters cleared.

## Timing
- Reset values: `evt_valid`=0, `evt_code`=0x00, `evt_break`=0, `evt_ext`=0, `held_code`=0x00, `err`=0, `overflow`=0.
- Event-completing `byte_valid` in cycle N -> FIFO write at end of N. `evt_valid`=1 in N+1 if the FIFO was empty. `held_code` updates in N+1.
- Handshake: the head is held stable while `evt_valid`&&!`evt_ready`. A pop in cycle N exposes the next entry in N+1.
- `err` is high for exactly cycle N+1 after the triggering byte or the timeout terminal cycle.
- Back-to-back `byte_valid` on consecutive cycles is supported.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined: a make event whose {code, ext} equals the currently held key is not pushed (auto-repeat suppressed). `held_code` is unchanged.
- Not defined: every make is pushed, including repeats.

## Structure
- Shared package `ps2_pkg`: prefix constants (E0, F0, E1, AA, FA, FE, 00, FF), state enum, event struct {code[7:0], brk, ext}.
- One sub-module, `ps2_evt_fifo` (parameter DEPTH, show-ahead, count-based full/empty). The FSM, timeout and held-key logic live in `ps2_key_ctrl`.

## Test plan
- Bytes 1C, F0 1C with `evt_ready`=1 -> events {1C,0,0} then {1C,1,0}. `held_code` goes 1C then 00.
- Bytes E0 75, E0 F0 75 -> {75,0,1}, {75,1,1}. A break of 0x1C while 0x75 is held leaves `held_code`=75.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}, and no event from the inner bytes.
- E0, then no byte for `TIMEOUT_CYC` cycles -> one `err` pulse, no event. A following 1C gives {1C,0,1}... no: gives {1C,0,0}.
- `evt_ready`=0 and makes 15,16,17,18,19 pushed (macro off) -> first 4 retained, 19 dropped, `overflow`=1. Pops return 15..18 in order.
- Macro on: 1C 1C 1C F0 1C -> events {1C,0,0},{1C,1,0} only. Macro off: three makes, then the break.
